// File: rtl/rapid_pkg.sv
// rapid_pkg: shared memory-op types, RV32 load/store size codes and bus defaults
package rapid_pkg;
  localparam int RAPID_XLEN = 32;
  localparam int DMEM_ACK_TIMEOUT = 255;
  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_e;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
    return funct3[1] ? (addr != 2'b00) : (funct3[0] & addr[0]);
  endfunction
endpackage

// File: rtl/load_data_align.sv
// load_data_align: picks the addressed byte/half of a load word and sign/zero extends it
module load_data_align
  import rapid_pkg::*;
#(
  parameter int XLEN = RAPID_XLEN
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_addr,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data
);
  logic [7:0]  b;
  logic [15:0] h;
  // lane select by address, then extend according to size and signedness
  always_comb begin
    b = i_rdata[{i_addr, 3'b000} +: 8];
    h = i_rdata[{i_addr[1], 4'b0000} +: 16];
    o_data = (i_funct3 == F3_LB)  ? {{(XLEN-8){b[7]}}, b} :
             (i_funct3 == F3_LBU) ? {{(XLEN-8){1'b0}}, b} :
             (i_funct3 == F3_LH)  ? {{(XLEN-16){h[15]}}, h} :
             (i_funct3 == F3_LHU) ? {{(XLEN-16){1'b0}}, h} : i_rdata;
  end
endmodule

// File: rtl/mem_writeback_stage.sv
// mem_writeback_stage: runs load/store bus transactions and drives the register-file write port
module mem_writeback_stage
  import rapid_pkg::*;
#(
  parameter int XLEN        = RAPID_XLEN,
  parameter int ACK_TIMEOUT = DMEM_ACK_TIMEOUT
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_op,
  input  logic [2:0]      i_funct3,
  input  logic [4:0]      i_rd,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic [XLEN-1:0] i_store_data,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [3:0]      o_dmem_be,
  input  logic            i_dmem_ack,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_misaligned,
  output logic            o_bus_error
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);
  typedef enum logic {IDLE, WAIT_ACK} state_e;
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [4:0]      pend_rd_q, pend_rd_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            mis_q, mis_d;
  logic            berr_q, berr_d;
  logic [3:0]      be_new;
  logic [XLEN-1:0] wdata_new;
  logic [XLEN-1:0] load_data;
  logic            is_mem;
  load_data_align #(.XLEN(XLEN)) u_align (
    .i_rdata  (i_dmem_rdata),
    .i_addr   (addr_q[1:0]),
    .i_funct3 (funct3_q),
    .o_data   (load_data)
  );
  // byte enables and lane-replicated store data for the op being offered
  always_comb begin
    is_mem = (i_op == MEM_LOAD) || (i_op == MEM_STORE);
    be_new = (i_funct3[1:0] == F3_SB[1:0]) ? 4'b0001 << i_alu_result[1:0] :
             (i_funct3[1:0] == F3_SH[1:0]) ? (i_alu_result[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_new = (i_funct3[1:0] == F3_SB[1:0]) ? {4{i_store_data[7:0]}} :
                (i_funct3[1:0] == F3_SW[1:0]) ? i_store_data : {2{i_store_data[15:0]}};
  end
  // FSM next state, request latching, ack timeout and writeback selection
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    funct3_d  = funct3_q;
    pend_rd_d = pend_rd_q;
    wb_rd_d   = '0;
    wb_data_d = wb_data_q;
    mis_d     = 1'b0;
    berr_d    = 1'b0;
    if (state_q == IDLE) begin
      if (i_valid && !is_mem) begin
        wb_rd_d   = i_rd;
        wb_data_d = i_alu_result;
      end else if (i_valid && is_misaligned(i_funct3, i_alu_result[1:0])) begin
        mis_d = 1'b1;
      end else if (i_valid) begin
        state_d   = WAIT_ACK;
        cnt_d     = '0;
        we_d      = (i_op == MEM_STORE);
        addr_d    = i_alu_result;
        wdata_d   = wdata_new;
        be_d      = be_new;
        funct3_d  = i_funct3;
        pend_rd_d = i_rd;
      end
    end else if (i_dmem_ack) begin
      state_d   = IDLE;
      wb_rd_d   = we_q ? 5'd0 : pend_rd_q;
      wb_data_d = we_q ? wb_data_q : load_data;
    end else if (cnt_q == CNT_LAST) begin
      state_d = IDLE;
      berr_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  // state and output registers; reset drops any outstanding request at once
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      funct3_q  <= '0;
      pend_rd_q <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      mis_q     <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      funct3_q  <= funct3_d;
      pend_rd_q <= pend_rd_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      mis_q     <= mis_d;
      berr_q    <= berr_d;
    end
  end
  assign o_ready      = (state_q == IDLE);
  assign o_dmem_req   = (state_q == WAIT_ACK);
  assign o_dmem_we    = we_q;
  assign o_dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign o_dmem_wdata = wdata_q;
  assign o_dmem_be    = be_q;
  assign o_rd         = wb_rd_q;
  assign o_rd_data    = wb_data_q;
  assign o_misaligned = mis_q;
  assign o_bus_error  = berr_q;
endmodule

// File: tb/tb_mem_writeback_stage.sv
// tb_mem_writeback_stage: randomized and directed checks of the memory/writeback stage
module tb_mem_writeback_stage;
  import rapid_pkg::*;
  localparam int TO = 4;
  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [1:0]  i_op = 2'd0;
  logic [2:0]  i_funct3 = 3'd0;
  logic [4:0]  i_rd = 5'd0;
  logic [31:0] i_alu_result = '0;
  logic [31:0] i_store_data = '0;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [31:0] o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_ack = 1'b0;
  logic [31:0] i_dmem_rdata = '0;
  logic [4:0]  o_rd;
  logic [31:0] o_rd_data;
  logic        o_misaligned;
  logic        o_bus_error;

  mem_writeback_stage #(.XLEN(32), .ACK_TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_funct3(i_funct3), .i_rd(i_rd), .i_alu_result(i_alu_result),
    .i_store_data(i_store_data), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
    .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata), .o_rd(o_rd), .o_rd_data(o_rd_data),
    .o_misaligned(o_misaligned), .o_bus_error(o_bus_error)
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int miscompares = 0;

  // what one transaction looked like from outside
  int          req_cycles, wr_cnt, mis_cnt, berr_cnt;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data, s_addr, s_wdata;
  logic [3:0]  s_be;
  logic        s_we, stable, ready_low, rdy_after, rd_at_accept;

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic model_mis(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a % 4) % size_of(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int k;
    int v;
    k = int'(a % 4);
    if (size_of(f3) == 4) return w;
    v = (size_of(f3) == 1) ? int'((w >> (8 * k)) % 256) : int'((w >> (8 * k)) % 65536);
    if (f3 == F3_LB && v >= 128) v = v - 256;
    if (f3 == F3_LH && v >= 32768) v = v - 65536;
    return 32'(v);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int m;
    m = ((1 << size_of(f3)) - 1) << int'(a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (size_of(f3) == 1) return (d % 256) * 32'h0101_0101;
    if (size_of(f3) == 2) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  // offers one op, then watches the bus and writeback port for TO+4 cycles
  task automatic run_mem(input logic [1:0] op, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] sdata, input int ack_at,
                         input logic [31:0] rdata);
    req_cycles = 0; wr_cnt = 0; mis_cnt = 0; berr_cnt = 0; wr_rd = '0; wr_data = '0;
    stable = 1'b1; ready_low = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b1; i_op = op; i_funct3 = f3; i_rd = rd; i_alu_result = addr; i_store_data = sdata;
    @(negedge i_clk);
    i_valid = 1'b0; i_op = MEM_STORE; i_funct3 = 3'($urandom); i_rd = 5'($urandom);
    i_alu_result = $urandom; i_store_data = $urandom;
    rdy_after = o_ready;
    rd_at_accept = (o_rd != 5'd0);
    if (o_misaligned) mis_cnt++;
    if (o_bus_error) berr_cnt++;
    for (int c = 1; c <= TO + 4; c++) begin
      if (o_dmem_req) begin
        req_cycles++;
        if (o_ready) ready_low = 1'b0;
        if (req_cycles == 1) begin
          s_addr = o_dmem_addr; s_wdata = o_dmem_wdata; s_be = o_dmem_be; s_we = o_dmem_we;
        end else if ({o_dmem_addr, o_dmem_wdata, o_dmem_be, o_dmem_we} !== {s_addr, s_wdata, s_be, s_we}) begin
          stable = 1'b0;
        end
        if (req_cycles == ack_at) begin
          i_dmem_ack = 1'b1;
          i_dmem_rdata = rdata;
        end
      end
      @(negedge i_clk);
      i_dmem_ack = 1'b0;
      i_dmem_rdata = $urandom;
      if (o_rd != 5'd0) begin
        wr_cnt++; wr_rd = o_rd; wr_data = o_rd_data;
      end
      if (o_misaligned) mis_cnt++;
      if (o_bus_error) berr_cnt++;
    end
  endtask

  task automatic test_reset();
    #2 i_reset_n = 1'b0;
    #1;
    vectors++; if (o_dmem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b expected 0", o_dmem_req); end
    vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
    vectors++; if (o_rd !== 5'd0) begin miscompares++; $display("FAIL reset_rd: got %0d expected 0", o_rd); end
    vectors++; if (o_rd_data !== 32'd0) begin miscompares++; $display("FAIL reset_rd_data: got %h expected 0", o_rd_data); end
    vectors++; if ({o_misaligned, o_bus_error} !== 2'b00) begin miscompares++; $display("FAIL reset_pulses: got %b expected 00", {o_misaligned, o_bus_error}); end
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  task automatic test_alu_back_to_back();
    logic [4:0]  prd;
    logic [31:0] pres;
    logic        pend;
    pend = 1'b0; prd = '0; pres = '0;
    for (int n = 0; n < 26; n++) begin
      @(negedge i_clk);
      if (pend) begin
        vectors++; if (o_rd !== prd) begin miscompares++; $display("FAIL alu_rd[%0d]: got %0d expected %0d", n, o_rd, prd); end
        if (prd != 5'd0) begin
          vectors++; if (o_rd_data !== pres) begin miscompares++; $display("FAIL alu_data[%0d]: got %h expected %h", n, o_rd_data, pres); end
        end
        vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL alu_ready[%0d]: got %b expected 1", n, o_ready); end
      end
      if (n == 25) begin
        i_valid = 1'b0;
      end else begin
        prd  = (n == 0) ? 5'd5 : 5'($urandom);
        pres = (n == 0) ? 32'h1234 : $urandom;
        i_valid = 1'b1; i_op = MEM_NONE; i_rd = prd; i_alu_result = pres;
        pend = 1'b1;
      end
    end
    @(negedge i_clk);
    vectors++; if (o_rd !== 5'd0) begin miscompares++; $display("FAIL alu_idle_rd: got %0d expected 0", o_rd); end
  endtask

  task automatic test_load_extend();
    run_mem(MEM_LOAD, F3_LB, 5'd7, 32'h103, 32'd0, 3, 32'h80FF_FF00);
    vectors++; if (wr_data !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL lb_data: got %h expected ffffff80", wr_data); end
    vectors++; if (wr_rd !== 5'd7) begin miscompares++; $display("FAIL lb_rd: got %0d expected 7", wr_rd); end
    vectors++; if (req_cycles !== 3) begin miscompares++; $display("FAIL lb_req_cycles: got %0d expected 3", req_cycles); end
    vectors++; if (ready_low !== 1'b1) begin miscompares++; $display("FAIL lb_ready_low: got %b expected 1", ready_low); end
    run_mem(MEM_LOAD, F3_LBU, 5'd7, 32'h103, 32'd0, 3, 32'h80FF_FF00);
    vectors++; if (wr_data !== 32'h0000_0080) begin miscompares++; $display("FAIL lbu_data: got %h expected 00000080", wr_data); end
    vectors++; if (wr_cnt !== 1) begin miscompares++; $display("FAIL lbu_wr_cnt: got %0d expected 1", wr_cnt); end
  endtask

  task automatic test_store_half();
    run_mem(MEM_STORE, F3_SH, 5'd9, 32'h102, 32'h1234_ABCD, 2, 32'hDEAD_BEEF);
    vectors++; if (s_be !== 4'b1100) begin miscompares++; $display("FAIL sh_be: got %b expected 1100", s_be); end
    vectors++; if (s_wdata !== 32'hABCD_ABCD) begin miscompares++; $display("FAIL sh_wdata: got %h expected abcdabcd", s_wdata); end
    vectors++; if (s_addr !== 32'h100) begin miscompares++; $display("FAIL sh_addr: got %h expected 00000100", s_addr); end
    vectors++; if (s_we !== 1'b1) begin miscompares++; $display("FAIL sh_we: got %b expected 1", s_we); end
    vectors++; if (wr_cnt !== 0) begin miscompares++; $display("FAIL sh_no_write: got %0d writes expected 0", wr_cnt); end
  endtask

  task automatic test_misaligned();
    @(negedge i_clk);
    i_valid = 1'b1; i_op = MEM_LOAD; i_funct3 = F3_LW; i_rd = 5'd3; i_alu_result = 32'h101;
    @(negedge i_clk);
    vectors++; if (o_misaligned !== 1'b1) begin miscompares++; $display("FAIL mis_pulse: got %b expected 1", o_misaligned); end
    vectors++; if (o_dmem_req !== 1'b0) begin miscompares++; $display("FAIL mis_req: got %b expected 0", o_dmem_req); end
    vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL mis_ready: got %b expected 1", o_ready); end
    vectors++; if (o_rd !== 5'd0) begin miscompares++; $display("FAIL mis_rd: got %0d expected 0", o_rd); end
    i_op = MEM_NONE; i_rd = 5'd4; i_alu_result = 32'h55AA_0001;
    @(negedge i_clk);
    i_valid = 1'b0;
    vectors++; if (o_misaligned !== 1'b0) begin miscompares++; $display("FAIL mis_one_cycle: got %b expected 0", o_misaligned); end
    vectors++; if ({o_rd, o_rd_data} !== {5'd4, 32'h55AA_0001}) begin miscompares++; $display("FAIL mis_next_op: got %0d/%h expected 4/55aa0001", o_rd, o_rd_data); end
  endtask

  task automatic test_timeout();
    run_mem(MEM_LOAD, F3_LW, 5'd12, 32'h200, 32'd0, 0, 32'd0);
    vectors++; if (req_cycles !== TO) begin miscompares++; $display("FAIL to_req_cycles: got %0d expected %0d", req_cycles, TO); end
    vectors++; if (berr_cnt !== 1) begin miscompares++; $display("FAIL to_bus_error: got %0d pulses expected 1", berr_cnt); end
    vectors++; if (wr_cnt !== 0) begin miscompares++; $display("FAIL to_no_write: got %0d writes expected 0", wr_cnt); end
    run_mem(MEM_LOAD, F3_LW, 5'd12, 32'h200, 32'd0, TO, 32'hCAFE_F00D);
    vectors++; if (berr_cnt !== 0) begin miscompares++; $display("FAIL to_ack_wins_err: got %0d pulses expected 0", berr_cnt); end
    vectors++; if ({wr_rd, wr_data} !== {5'd12, 32'hCAFE_F00D}) begin miscompares++; $display("FAIL to_ack_wins_wb: got %0d/%h expected 12/cafef00d", wr_rd, wr_data); end
  endtask

  task automatic test_ack_ignored();
    @(negedge i_clk);
    i_dmem_ack = 1'b1; i_dmem_rdata = $urandom;
    @(negedge i_clk);
    i_dmem_ack = 1'b0;
    vectors++; if ({o_rd, o_dmem_req, o_ready, o_bus_error} !== {5'd0, 1'b0, 1'b1, 1'b0}) begin miscompares++; $display("FAIL stray_ack: got rd=%0d req=%b rdy=%b err=%b expected 0/0/1/0", o_rd, o_dmem_req, o_ready, o_bus_error); end
  endtask

  task automatic test_reset_mid();
    @(negedge i_clk);
    i_valid = 1'b1; i_op = MEM_LOAD; i_funct3 = F3_LW; i_rd = 5'd20; i_alu_result = 32'h300;
    @(negedge i_clk);
    i_valid = 1'b0;
    vectors++; if (o_dmem_req !== 1'b1) begin miscompares++; $display("FAIL rst_mid_req_before: got %b expected 1", o_dmem_req); end
    #2 i_reset_n = 1'b0;
    #1;
    vectors++; if ({o_dmem_req, o_rd} !== {1'b0, 5'd0}) begin miscompares++; $display("FAIL rst_mid_async: got req=%b rd=%0d expected 0/0", o_dmem_req, o_rd); end
    @(negedge i_clk);
    i_reset_n = 1'b1; i_dmem_ack = 1'b1; i_dmem_rdata = 32'h1111_2222;
    @(negedge i_clk);
    i_dmem_ack = 1'b0;
    vectors++; if ({o_ready, o_dmem_req, o_rd} !== {1'b1, 1'b0, 5'd0}) begin miscompares++; $display("FAIL rst_mid_after: got rdy=%b req=%b rd=%0d expected 1/0/0", o_ready, o_dmem_req, o_rd); end
  endtask

  task automatic test_random();
    logic [2:0]  lf3 [5];
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] addr, sdata, rdata;
    int          ack_at, exp_req;
    logic        mis, acked, exp_wr;
    lf3 = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(1) == 0) ? 2'(MEM_LOAD) : 2'(MEM_STORE);
      f3 = (op == MEM_STORE) ? 3'($urandom_range(2)) : lf3[$urandom_range(4)];
      rd = 5'($urandom);
      addr = $urandom;
      if ($urandom_range(2) != 0) addr = addr - (addr % size_of(f3));
      ack_at = $urandom_range(TO + 1);
      sdata = $urandom;
      rdata = $urandom;
      run_mem(op, f3, rd, addr, sdata, ack_at, rdata);
      mis = model_mis(f3, addr);
      acked = !mis && ack_at >= 1 && ack_at <= TO;
      exp_req = mis ? 0 : (acked ? ack_at : TO);
      exp_wr = acked && op == MEM_LOAD && rd != 5'd0;
      vectors++; if (req_cycles !== exp_req) begin miscompares++; $display("FAIL rnd_req_cycles[%0d]: got %0d expected %0d", n, req_cycles, exp_req); end
      vectors++; if (mis_cnt !== int'(mis)) begin miscompares++; $display("FAIL rnd_misaligned[%0d]: got %0d expected %0d", n, mis_cnt, mis); end
      vectors++; if (berr_cnt !== int'(!mis && !acked)) begin miscompares++; $display("FAIL rnd_bus_error[%0d]: got %0d expected %0d", n, berr_cnt, !mis && !acked); end
      vectors++; if (wr_cnt !== int'(exp_wr)) begin miscompares++; $display("FAIL rnd_wr_cnt[%0d]: got %0d expected %0d", n, wr_cnt, exp_wr); end
      vectors++; if (rdy_after !== mis) begin miscompares++; $display("FAIL rnd_ready[%0d]: got %b expected %b", n, rdy_after, mis); end
      vectors++; if (rd_at_accept !== 1'b0) begin miscompares++; $display("FAIL rnd_rd_at_accept[%0d]: got %b expected 0", n, rd_at_accept); end
      if (exp_wr) begin
        vectors++; if ({wr_rd, wr_data} !== {rd, model_load(f3, addr, rdata)}) begin miscompares++; $display("FAIL rnd_wb[%0d]: got %0d/%h expected %0d/%h", n, wr_rd, wr_data, rd, model_load(f3, addr, rdata)); end
      end
      if (!mis) begin
        vectors++; if ({stable, ready_low} !== 2'b11) begin miscompares++; $display("FAIL rnd_hold[%0d]: got stable=%b ready_low=%b expected 1/1", n, stable, ready_low); end
        vectors++; if ({s_addr, s_we} !== {addr & 32'hFFFF_FFFC, op == MEM_STORE}) begin miscompares++; $display("FAIL rnd_addr_we[%0d]: got %h/%b expected %h/%b", n, s_addr, s_we, addr & 32'hFFFF_FFFC, op == MEM_STORE); end
      end
      if (!mis && op == MEM_STORE) begin
        vectors++; if ({s_be, s_wdata} !== {model_be(f3, addr), model_wdata(f3, sdata)}) begin miscompares++; $display("FAIL rnd_store_lanes[%0d]: got %b/%h expected %b/%h", n, s_be, s_wdata, model_be(f3, addr), model_wdata(f3, sdata)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_back_to_back();
    test_load_extend();
    test_store_half();
    test_misaligned();
    test_timeout();
    test_ack_ignored();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
